wb_stage_pipe: RTL and testbench
================================

// Module: wb_stage_pipe
// PURPOSE
//  Registered, pipelined write-back stage. Sits after memory access and drives the
//  register-file write port in decode. Holds a load until the memory controller
//  returns data (variable latency) and stalls upstream meanwhile.
//  Reports memory timeouts and orphan returns.
// PARAMETERS
//  N            32   datapath width
//  RA           5    register-address width
//  MEM_TIMEOUT  64   max WAIT_MEM cycles before abort (>=1)
// PORTS
//  clk          in   1    clock
//  rst          in   1    synchronous reset, active-high
//  in_valid     in   1    upstream instruction valid
//  in_ready     out  1    stage can accept; = (state==IDLE) && !rst
//  in_exe       in   N    ALU result
//  in_pcinc     in   N    PC+4 (link value)
//  in_rx        in   RA   destination from opcode
//  in_lr        in   RA   link-register address
//  in_datasel   in   2    00/01 = pcinc, 10 = memory (load), 11 = exe
//  in_regsel    in   1    1 = in_lr, 0 = in_rx
//  in_wben      in   1    instruction writes a register
//  in_lsize     in   2    00 word, 01 half, 10 byte (WB_LOAD_EXT_EN only)
//  in_lsign     in   1    1 = sign-extend sub-word load (WB_LOAD_EXT_EN only)
//  in_laddr     in   2    load byte offset (WB_LOAD_EXT_EN only)
//  mem_valid    in   1    mem_data valid this cycle
//  mem_data     in   N    load data from memory controller
//  wb_we        out  1    register-file write enable (1-cycle pulse)
//  wb_reg       out  RA   register-file write address
//  wb_data      out  N    register-file write data
//  timeout_err  out  1    sticky: load aborted after MEM_TIMEOUT cycles
//  orphan_err   out  1    sticky: mem_valid seen in IDLE
// BEHAVIOUR
//  - Reset: state IDLE, wait counter 0; wb_we, wb_reg, wb_data, timeout_err and
//    orphan_err are 0.
//  - Accept = in_valid && in_ready. Dest = in_regsel ? in_lr : in_rx.
//  - Non-load accept (datasel != 10): the next cycle, wb_we = in_wben && (dest != 0),
//    wb_reg = dest, wb_data = pcinc or exe. Latency 1. Back-to-back accepts run
//    every cycle.
//  - Load accept (datasel == 10): capture dest/wben/lsize/lsign/laddr; go to WAIT_MEM
//    and clear the counter. mem_valid in the accept cycle is treated as orphan.
//  - WAIT_MEM: in_ready = 0 and the counter increments each cycle. When mem_valid
//    is 1, the next cycle drives wb_we = wben && (dest != 0), wb_reg = dest,
//    wb_data = formatted mem_data; the state returns to IDLE. The first new accept
//    can occur in the cycle after mem_valid.
//  - Timeout: if the counter reaches MEM_TIMEOUT with no mem_valid, set timeout_err,
//    do not write, return to IDLE. mem_valid in that same cycle takes priority:
//    the write happens and there is no error.
//  - mem_valid in IDLE: ignored for writes; sets orphan_err.
//  - wb_we is 0 in every cycle that does not follow a completion. wb_reg and
//    wb_data hold their last values.
//  - rst mid-WAIT_MEM: the pending load is dropped with no write. A late mem_valid
//    after reset sets orphan_err.
//  - Sticky errors clear only on rst.
// CONFIGURATION
//  WB_LOAD_EXT_EN defined:
//    - Half load: lane = mem_data[16*in_laddr[1] +: 16]; in_laddr[0] is ignored.
//    - Byte load: lane = mem_data[8*in_laddr +: 8].
//    - The selected lane is sign-extended (lsign = 1) or zero-extended to N.
//    - Word load, and lsize = 11, pass mem_data unchanged.
//  WB_LOAD_EXT_EN undefined: mem_data passes unchanged; in_lsize, in_lsign and
//    in_laddr are ignored.
// TESTING
//  1. ALU op: datasel = 11, exe = 0xDEADBEEF, rx = 5, wben = 1 -> the next cycle
//     has wb_we = 1, wb_reg = 5, wb_data = 0xDEADBEEF.
//  2. Link: datasel = 01, regsel = 1, lr = 31, pcinc = 0x104 -> wb_reg = 31,
//     wb_data = 0x104. With rx = 0, regsel = 0: wb_we = 0.
//  3. Load with mem_valid 3 cycles after accept, mem_data = 0x12345678 -> in_ready
//     is 0 for 3 cycles; then wb_data = 0x12345678, then in_ready = 1.
//  4. MEM_TIMEOUT = 4, no mem_valid -> timeout_err = 1, no wb_we, IDLE after 4 cycles.
//  5. mem_valid pulse in IDLE -> orphan_err = 1 and wb_we stays 0; rst during
//     WAIT_MEM -> no write and errors cleared.
//  6. WB_LOAD_EXT_EN: byte, laddr = 2, lsign = 1, mem_data = 0x00800000 ->
//     wb_data = 0xFFFFFF80; with lsign = 0 -> 0x00000080.

Source files
------------

// File: rtl/wb_stage_pipe.sv
// ---------------------------------------------------------------------------
// wb_stage_pipe -- registered, pipelined write-back stage.
//
// Sits after memory access and drives the register-file write port. ALU and
// link results are written one cycle after they are accepted. A load is held
// until the memory controller returns data (variable latency), and upstream
// is stalled meanwhile. Memory timeouts and orphan memory returns are
// reported on sticky error flags that clear only on reset.
//
// Optional feature macro: WB_LOAD_EXT_EN
//   defined   : sub-word loads (half/byte) are lane-selected by the byte
//               offset and sign- or zero-extended to N bits.
//   undefined : load data passes through unchanged; in_lsize, in_lsign and
//               in_laddr are ignored.
//
// Handshake: an instruction is accepted in any cycle where in_valid and
// in_ready are both 1. in_ready is 1 only while no load is outstanding and
// reset is low. There is no back-pressure on the write port: wb_we is a
// one-cycle pulse and the register file must take it.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   in_valid / in_ready       upstream handshake
//   in_exe, in_pcinc          ALU result, PC+4 (link value)
//   in_rx, in_lr, in_regsel   destination select (1 = in_lr, 0 = in_rx)
//   in_datasel                00/01 pcinc, 10 memory load, 11 exe
//   in_wben                   instruction writes a register
//   in_lsize/in_lsign/in_laddr  load size, sign, byte offset (ext only)
//   mem_valid, mem_data       load return from the memory controller
//   wb_we, wb_reg, wb_data    register-file write port
//   timeout_err, orphan_err   sticky error flags
// ---------------------------------------------------------------------------
module wb_stage_pipe #(
  parameter int N           = 32,
  parameter int RA          = 5,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_exe,
  input  logic [N-1:0]  in_pcinc,
  input  logic [RA-1:0] in_rx,
  input  logic [RA-1:0] in_lr,
  input  logic [1:0]    in_datasel,
  input  logic          in_regsel,
  input  logic          in_wben,
  input  logic [1:0]    in_lsize,
  input  logic          in_lsign,
  input  logic [1:0]    in_laddr,
  input  logic          mem_valid,
  input  logic [N-1:0]  mem_data,
  output logic          wb_we,
  output logic [RA-1:0] wb_reg,
  output logic [N-1:0]  wb_data,
  output logic          timeout_err,
  output logic          orphan_err
);

  // Counter must hold 0 .. MEM_TIMEOUT-1.
  localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } state_t;

  state_t        state, stateNext;
  logic [CW-1:0] waitCnt, waitCntNext;

  // Captured load context, used when the memory data returns.
  logic [RA-1:0] pendReg;
  logic          pendWben;

  logic [RA-1:0] dest;
  logic [N-1:0]  memFormatted;

  logic          weNext;
  logic          wbUpd;
  logic [RA-1:0] regNext;
  logic [N-1:0]  dataNext;
  logic          capture;
  logic          setTimeout;
  logic          setOrphan;

  assign dest     = in_regsel ? in_lr : in_rx;
  assign in_ready = (state == IDLE) && !rst;

`ifdef WB_LOAD_EXT_EN
  logic [1:0] pendSize;
  logic       pendSign;
  logic [1:0] pendAddr;

  function automatic logic [N-1:0] fmtLoad(
    input logic [N-1:0] data,
    input logic [1:0]   size,
    input logic         sign,
    input logic [1:0]   addr
  );
    logic [15:0]  half;
    logic [7:0]   lane8;
    logic [N-1:0] res;
    half  = addr[1] ? data[31:16] : data[15:0];
    case (addr)
      2'd0:    lane8 = data[7:0];
      2'd1:    lane8 = data[15:8];
      2'd2:    lane8 = data[23:16];
      default: lane8 = data[31:24];
    endcase
    case (size)
      2'b01:   res = {{(N-16){sign & half[15]}}, half};
      2'b10:   res = {{(N-8){sign & lane8[7]}}, lane8};
      default: res = data;  // word, and the unused 11 encoding
    endcase
    return res;
  endfunction

  assign memFormatted = fmtLoad(mem_data, pendSize, pendSign, pendAddr);
`else
  logic unusedExtInputs;
  assign unusedExtInputs = ^{in_lsize, in_lsign, in_laddr};
  assign memFormatted    = mem_data;
`endif

  always_comb begin
    stateNext   = state;
    waitCntNext = waitCnt;
    weNext      = 1'b0;
    wbUpd       = 1'b0;
    regNext     = wb_reg;
    dataNext    = wb_data;
    capture     = 1'b0;
    setTimeout  = 1'b0;
    setOrphan   = 1'b0;
    case (state)
      IDLE: begin
        // Any memory return while no load is outstanding is an orphan,
        // including the cycle in which a load is being accepted.
        if (mem_valid) setOrphan = 1'b1;
        if (in_valid) begin
          if (in_datasel == 2'b10) begin
            capture     = 1'b1;
            stateNext   = WAIT_MEM;
            waitCntNext = '0;
          end else begin
            wbUpd    = 1'b1;
            weNext   = in_wben && (dest != '0);
            regNext  = dest;
            dataNext = (in_datasel == 2'b11) ? in_exe : in_pcinc;
          end
        end
      end
      WAIT_MEM: begin
        // A return in the final allowed cycle still wins over the timeout.
        if (mem_valid) begin
          wbUpd       = 1'b1;
          weNext      = pendWben && (pendReg != '0);
          regNext     = pendReg;
          dataNext    = memFormatted;
          stateNext   = IDLE;
          waitCntNext = '0;
        end else if (waitCnt == CNT_LAST) begin
          setTimeout  = 1'b1;
          stateNext   = IDLE;
          waitCntNext = '0;
        end else begin
          waitCntNext = waitCnt + 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      waitCnt     <= '0;
      wb_we       <= 1'b0;
      wb_reg      <= '0;
      wb_data     <= '0;
      timeout_err <= 1'b0;
      orphan_err  <= 1'b0;
      pendReg     <= '0;
      pendWben    <= 1'b0;
`ifdef WB_LOAD_EXT_EN
      pendSize    <= 2'b00;
      pendSign    <= 1'b0;
      pendAddr    <= 2'b00;
`endif
    end else begin
      state   <= stateNext;
      waitCnt <= waitCntNext;
      wb_we   <= weNext;
      if (wbUpd) begin
        wb_reg  <= regNext;
        wb_data <= dataNext;
      end
      if (capture) begin
        pendReg  <= dest;
        pendWben <= in_wben;
`ifdef WB_LOAD_EXT_EN
        pendSize <= in_lsize;
        pendSign <= in_lsign;
        pendAddr <= in_laddr;
`endif
      end
      if (setTimeout) timeout_err <= 1'b1;
      if (setOrphan)  orphan_err  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_stage_pipe.sv
// ---------------------------------------------------------------------------
// tb_wb_stage_pipe -- self-checking bench for wb_stage_pipe.
//
// Inputs are driven and outputs sampled on the falling clock edge. Each
// transaction (ALU/link op, load with a chosen memory latency, orphan pulse,
// reset) is expanded by the bench into the cycle-by-cycle outcome it must
// produce; expected register writes go through exp_q. Built with
// MEM_TIMEOUT = 4 so timeouts are reached often.
// ---------------------------------------------------------------------------
module tb_wb_stage_pipe;

  localparam int N      = 32;
  localparam int RA     = 5;
  localparam int MEM_TO = 4;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_exe;
  logic [N-1:0]  in_pcinc;
  logic [RA-1:0] in_rx;
  logic [RA-1:0] in_lr;
  logic [1:0]    in_datasel;
  logic          in_regsel;
  logic          in_wben;
  logic [1:0]    in_lsize;
  logic          in_lsign;
  logic [1:0]    in_laddr;
  logic          mem_valid;
  logic [N-1:0]  mem_data;
  logic          wb_we;
  logic [RA-1:0] wb_reg;
  logic [N-1:0]  wb_data;
  logic          timeout_err;
  logic          orphan_err;

  always #5 clk = ~clk;

  wb_stage_pipe #(.N(N), .RA(RA), .MEM_TIMEOUT(MEM_TO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_exe(in_exe), .in_pcinc(in_pcinc), .in_rx(in_rx), .in_lr(in_lr),
    .in_datasel(in_datasel), .in_regsel(in_regsel), .in_wben(in_wben),
    .in_lsize(in_lsize), .in_lsign(in_lsign), .in_laddr(in_laddr),
    .mem_valid(mem_valid), .mem_data(mem_data), .wb_we(wb_we),
    .wb_reg(wb_reg), .wb_data(wb_data), .timeout_err(timeout_err),
    .orphan_err(orphan_err)
  );

  // ---------------- scoreboard ----------------
  int vectors     = 0;
  int miscompares = 0;

  logic [RA+N:0] exp_q[$];   // {we, reg, data} for the cycle being checked
  logic [RA-1:0] last_reg  = '0;
  logic [N-1:0]  last_data = '0;
  logic          exp_to    = 1'b0;
  logic          exp_orph  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic expect_wb(input logic we, input logic [RA-1:0] r, input logic [N-1:0] d);
    exp_q.push_back({we, r, d});
    last_reg  = r;
    last_data = d;
  endtask

  task automatic check_all(input string ctx, input logic exp_ready);
    logic [RA+N:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({ctx, ".wb_we"},   32'(wb_we),   32'(e[RA+N]));
      chk({ctx, ".wb_reg"},  32'(wb_reg),  32'(e[RA+N-1:N]));
      chk({ctx, ".wb_data"}, wb_data,      e[N-1:0]);
    end else begin
      chk({ctx, ".wb_we"},   32'(wb_we),   32'd0);
      chk({ctx, ".wb_reg"},  32'(wb_reg),  32'(last_reg));
      chk({ctx, ".wb_data"}, wb_data,      last_data);
    end
    chk({ctx, ".in_ready"},    32'(in_ready),    32'(exp_ready));
    chk({ctx, ".timeout_err"}, 32'(timeout_err), 32'(exp_to));
    chk({ctx, ".orphan_err"},  32'(orphan_err),  32'(exp_orph));
  endtask

  // Expected formatted load value from the lane/extension rules.
  function automatic logic [31:0] exp_fmt(input logic [31:0] d, input logic [1:0] sz,
                                          input logic sg, input logic [1:0] ad);
`ifdef WB_LOAD_EXT_EN
    int w;
    int sh;
    logic [31:0] mask;
    logic [31:0] lane;
    if (sz == 2'b01) begin
      w  = 16;
      sh = 16 * int'(ad[1]);
    end else if (sz == 2'b10) begin
      w  = 8;
      sh = 8 * int'(ad);
    end else begin
      return d;
    end
    mask = (32'h1 << w) - 32'h1;
    lane = (d >> sh) & mask;
    if (sg && lane[w-1]) lane = lane | ~mask;
    return lane;
`else
    return d;
`endif
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rand_fields();
    in_exe     = $urandom;
    in_pcinc   = $urandom;
    in_rx      = RA'($urandom_range(0, 31));
    in_lr      = RA'($urandom_range(0, 31));
    in_regsel  = 1'($urandom_range(0, 1));
    in_wben    = ($urandom_range(0, 7) != 0);
    in_lsize   = 2'($urandom_range(0, 3));
    in_lsign   = 1'($urandom_range(0, 1));
    in_laddr   = 2'($urandom_range(0, 3));
    in_datasel = 2'($urandom_range(0, 3));
  endtask

  task automatic set_op(input logic [1:0] ds, input logic [31:0] exe, input logic [31:0] pc,
                        input logic [RA-1:0] rx, input logic [RA-1:0] lr,
                        input logic rs, input logic wb);
    in_datasel = ds; in_exe = exe; in_pcinc = pc; in_rx = rx; in_lr = lr;
    in_regsel = rs; in_wben = wb; in_lsize = 2'b00; in_lsign = 1'b0; in_laddr = 2'b00;
  endtask

  // Fields already set with datasel != 10.
  task automatic issue_nonload(input logic orph);
    logic [RA-1:0] d;
    in_valid  = 1'b1;
    mem_valid = orph;
    mem_data  = $urandom;
    d = in_regsel ? in_lr : in_rx;
    step();
    if (orph) exp_orph = 1'b1;
    expect_wb(in_wben && (d != 0), d, (in_datasel == 2'b11) ? in_exe : in_pcinc);
    check_all("op", 1'b1);
    in_valid  = 1'b0;
    mem_valid = 1'b0;
  endtask

  task automatic nonload_burst(input int n);
    for (int k = 0; k < n; k++) begin
      rand_fields();
      if (in_datasel == 2'b10) in_datasel = 2'b11;
      issue_nonload($urandom_range(0, 7) == 0);
    end
    step();
    check_all("burst_idle", 1'b1);
  endtask

  // Fields already set with datasel = 10. lat = 0 means memory never
  // answers; lat > MEM_TO means it answers late, after the timeout.
  task automatic issue_load(input int lat, input logic orph, input logic [31:0] mdat);
    logic [RA-1:0] d;
    logic          wb;
    logic [1:0]    sz;
    logic          sg;
    logic [1:0]    ad;
    logic [31:0]   md;
    bit            done;
    d  = in_regsel ? in_lr : in_rx;
    wb = in_wben; sz = in_lsize; sg = in_lsign; ad = in_laddr;
    in_valid  = 1'b1;
    mem_valid = orph;
    mem_data  = $urandom;
    step();
    if (orph) exp_orph = 1'b1;
    check_all("ld_acc", 1'b0);
    done = 0;
    for (int c = 1; c <= MEM_TO + 2 && !done; c++) begin
      rand_fields();                 // junk upstream traffic must be ignored
      in_valid  = (c <= MEM_TO);
      mem_valid = (c == lat);
      md        = (c == lat) ? mdat : $urandom;
      mem_data  = md;
      step();
      if (c == lat && c <= MEM_TO) begin
        expect_wb(wb && (d != 0), d, exp_fmt(md, sz, sg, ad));
        in_valid = 1'b0;
        check_all("ld_done", 1'b1);
        done = 1;
      end else if (c == MEM_TO) begin
        exp_to   = 1'b1;
        in_valid = 1'b0;
        check_all("ld_timeout", 1'b1);
        if (lat <= MEM_TO) done = 1;
      end else if (c > MEM_TO) begin
        if (c == lat) begin
          exp_orph = 1'b1;
          done = 1;
        end
        check_all("ld_late", 1'b1);
      end else begin
        check_all("ld_wait", 1'b0);
      end
    end
    in_valid  = 1'b0;
    mem_valid = 1'b0;
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    mem_valid = 1'b0;
    rst = 1'b1;
    step();
    exp_q.delete();
    last_reg = '0; last_data = '0; exp_to = 1'b0; exp_orph = 1'b0;
    check_all("reset", 1'b0);
    rst = 1'b0;
  endtask

  task automatic orphan_pulse();
    in_valid  = 1'b0;
    mem_valid = 1'b1;
    mem_data  = $urandom;
    step();
    exp_orph = 1'b1;
    check_all("orphan", 1'b1);
    mem_valid = 1'b0;
  endtask

  // Load dropped by reset two cycles in, then a late return.
  task automatic reset_mid_load();
    rand_fields();
    in_datasel = 2'b10;
    in_valid   = 1'b1;
    mem_valid  = 1'b0;
    step();
    in_valid = 1'b0;
    check_all("rml_acc", 1'b0);
    step();
    check_all("rml_wait", 1'b0);
    do_reset();
    mem_valid = 1'b1;
    mem_data  = $urandom;
    step();
    exp_orph = 1'b1;
    check_all("rml_late", 1'b1);
    mem_valid = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1;
    in_valid = 1'b0; mem_valid = 1'b0; mem_data = '0;
    set_op(2'b00, 32'h0, 32'h0, '0, '0, 1'b0, 1'b0);
    @(negedge clk);
    step();
    check_all("reset", 1'b0);
    rst = 1'b0;
    step();
    check_all("idle", 1'b1);

    // ALU op
    set_op(2'b11, 32'hDEADBEEF, 32'h0, 5'd5, 5'd0, 1'b0, 1'b1);
    issue_nonload(1'b0);
    chk("t1_data", wb_data, 32'hDEADBEEF);

    // Link op, then write to r0 suppressed
    set_op(2'b01, 32'h0, 32'h104, 5'd3, 5'd31, 1'b1, 1'b1);
    issue_nonload(1'b0);
    chk("t2_reg", 32'(wb_reg), 32'd31);
    set_op(2'b01, 32'h0, 32'h108, 5'd0, 5'd31, 1'b0, 1'b1);
    issue_nonload(1'b0);

    // Load, return 3 cycles after accept
    set_op(2'b10, 32'h0, 32'h0, 5'd7, 5'd0, 1'b0, 1'b1);
    issue_load(3, 1'b0, 32'h12345678);
    chk("t3_data", wb_data, 32'h12345678);

    // Load that times out with no return, and one returning in the last cycle
    set_op(2'b10, 32'h0, 32'h0, 5'd9, 5'd0, 1'b0, 1'b1);
    issue_load(0, 1'b0, 32'h0);
    chk("t4_timeout", 32'(timeout_err), 32'd1);
    do_reset();
    set_op(2'b10, 32'h0, 32'h0, 5'd10, 5'd0, 1'b0, 1'b1);
    issue_load(MEM_TO, 1'b0, 32'hCAFEF00D);

    // Orphan, then reset during a load
    orphan_pulse();
    reset_mid_load();
    do_reset();

`ifdef WB_LOAD_EXT_EN
    set_op(2'b10, 32'h0, 32'h0, 5'd4, 5'd0, 1'b0, 1'b1);
    in_lsize = 2'b10; in_laddr = 2'd2; in_lsign = 1'b1;
    issue_load(1, 1'b0, 32'h00800000);
    chk("t6_signed", wb_data, 32'hFFFFFF80);
    set_op(2'b10, 32'h0, 32'h0, 5'd4, 5'd0, 1'b0, 1'b1);
    in_lsize = 2'b10; in_laddr = 2'd2; in_lsign = 1'b0;
    issue_load(2, 1'b0, 32'h00800000);
    chk("t6_unsigned", wb_data, 32'h00000080);
`endif

    // Random traffic
    for (int i = 0; i < 200; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 45) begin
        nonload_burst($urandom_range(1, 4));
      end else if (r < 85) begin
        rand_fields();
        in_datasel = 2'b10;
        issue_load($urandom_range(0, MEM_TO + 2), ($urandom_range(0, 9) == 0), $urandom);
      end else if (r < 92) begin
        orphan_pulse();
      end else if (r < 96) begin
        reset_mid_load();
      end else begin
        do_reset();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
